// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the uart_tx_dev peripheral.
//   - register offsets on the bridge word address ADD_I[3:2]
//   - CTRL / STATUS bit positions
//   - transmitter FSM state encoding
//   - data bits per frame and the parity helper
package uart_tx_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int CTRL_EN  = 32'sd0;
  localparam int CTRL_IE  = 32'sd1;
  localparam int CTRL_PEN = 32'sd2;
  localparam int CTRL_ODD = 32'sd3;

  localparam int STAT_BUSY      = 32'sd0;
  localparam int STAT_FULL      = 32'sd1;
  localparam int STAT_EMPTY     = 32'sd2;
  localparam int STAT_DONE      = 32'sd3;
  localparam int STAT_OVR       = 32'sd4;
  localparam int STAT_LEVEL_LSB = 32'sd5;

  localparam int FRAME_BITS = 32'sd8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } tx_state_e;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: bridge device-bus signals for uart_tx_dev.
//   ADD_I [1:0]  word address
//   WE_I         one-cycle write strobe
//   DAT_I [31:0] write data
//   DAT_O [31:0] read data (combinational on ADD_I)
// master = bridge side, slave = device side.
interface uart_tx_if;
  logic [1:0]  ADD_I;
  logic        WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;

  modport master (output ADD_I, output WE_I, output DAT_I, input DAT_O);
  modport slave  (input ADD_I, input WE_I, input DAT_I, output DAT_O);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous show-ahead FIFO.
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write request and data (accepted when not full, or when
//                a pop happens in the same cycle)
//   pop, dout    read request (ignored when empty) and head-of-queue data
//   full, empty, count  occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Occupancy flags and accepted push/pop strobes.
  always_comb begin
    empty_s   = (count_r == {CW{1'b0}});
    full_s    = (count_r == CW'(DEPTH));
    pop_ok_s  = pop & ~empty_s;
    push_ok_s = push & (~full_s | pop_ok_s);
  end

  // Storage, pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: transmit-only 8N1 UART on the bridge device bus.
//   CLK_I, RST_I  clock, asynchronous active-low reset
//   bus           uart_tx_if.slave (ADD_I, WE_I, DAT_I, DAT_O)
//   IRQ           level interrupt: queue drained and enabled
//   TXD           serial output, idle high, LSB first
// Registers: 0 CTRL, 1 STATUS, 2 TXDATA, 3 DIV.
// Build option UART_TX_PARITY_EN adds CTRL[2] PEN / CTRL[3] ODD and a
// parity bit between the data bits and the stop bit.
module uart_tx_dev #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 434
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  uart_tx_if.slave   bus,
  output logic       IRQ,
  output logic       TXD
);
  import uart_tx_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             ctrl_en_r;
  logic             ctrl_ie_r;
`ifdef UART_TX_PARITY_EN
  logic             ctrl_pen_r;
  logic             ctrl_odd_r;
  logic             parity_r;
`endif
  logic [DIV_W-1:0] div_r;
  logic             done_r;
  logic             ovr_r;
  logic             irq_r;
  logic             txd_r;
  tx_state_e        state_r;
  logic [7:0]       shift_r;
  logic [2:0]       bit_cnt_r;
  logic [DIV_W-1:0] baud_cnt_r;

  logic             wr_ctrl_s, wr_status_s, wr_txdata_s, wr_div_s;
  logic [7:0]       fifo_dout_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;
  logic             pop_s, busy_s, bit_end_s, stop_end_s;
  logic             done_set_s, ovr_set_s;
  logic [DIV_W-1:0] eff_div_m1_s;
  logic [2:0]       level_s;
  logic [31:0]      rdata_s;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (CLK_I),
    .rst_n (RST_I),
    .push  (wr_txdata_s),
    .din   (bus.DAT_I[7:0]),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Write decode, bit timing and FIFO/flag control strobes.
  always_comb begin
    wr_ctrl_s    = bus.WE_I && (bus.ADD_I == REG_CTRL);
    wr_status_s  = bus.WE_I && (bus.ADD_I == REG_STATUS);
    wr_txdata_s  = bus.WE_I && (bus.ADD_I == REG_TXDATA);
    wr_div_s     = bus.WE_I && (bus.ADD_I == REG_DIV);
    busy_s       = (state_r != ST_IDLE);
    bit_end_s    = (baud_cnt_r == {DIV_W{1'b0}});
    stop_end_s   = (state_r == ST_STOP) && bit_end_s;
    // A pop only happens where a new frame may start: idle, or the last
    // clock of a stop bit (back-to-back frames with no gap).
    pop_s        = ctrl_en_r && !fifo_empty_s && ((state_r == ST_IDLE) || stop_end_s);
    done_set_s   = stop_end_s && fifo_empty_s;
    // A full FIFO still takes the byte if a pop frees a slot this cycle.
    ovr_set_s    = wr_txdata_s && fifo_full_s && !pop_s;
    // Divisors below 2 are clamped to 2 clocks per bit.
    if (div_r < DIV_W'(2)) begin
      eff_div_m1_s = DIV_W'(1);
    end else begin
      eff_div_m1_s = div_r - DIV_W'(1);
    end
    if (int'(fifo_count_s) > 32'sd7) begin
      level_s = 3'd7;
    end else begin
      level_s = 3'(fifo_count_s);
    end
  end

  // Read mux; unused bits and TXDATA read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (bus.ADD_I)
      REG_CTRL: begin
        rdata_s[CTRL_EN] = ctrl_en_r;
        rdata_s[CTRL_IE] = ctrl_ie_r;
`ifdef UART_TX_PARITY_EN
        rdata_s[CTRL_PEN] = ctrl_pen_r;
        rdata_s[CTRL_ODD] = ctrl_odd_r;
`endif
      end
      REG_STATUS: begin
        rdata_s[STAT_BUSY]              = busy_s;
        rdata_s[STAT_FULL]              = fifo_full_s;
        rdata_s[STAT_EMPTY]             = fifo_empty_s;
        rdata_s[STAT_DONE]              = done_r;
        rdata_s[STAT_OVR]               = ovr_r;
        rdata_s[STAT_LEVEL_LSB +: 3]    = level_s;
      end
      REG_TXDATA: rdata_s = 32'd0;
      REG_DIV:    rdata_s[DIV_W-1:0] = div_r;
      default:    rdata_s = 32'd0;
    endcase
  end

  assign bus.DAT_O = rdata_s;

  // Register file: CTRL, DIV and the sticky DONE/OVR flags (set beats clear).
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ctrl_en_r  <= 1'b0;
      ctrl_ie_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      ctrl_pen_r <= 1'b0;
      ctrl_odd_r <= 1'b0;
`endif
      div_r      <= DIV_W'(DIV_RESET);
      done_r     <= 1'b0;
      ovr_r      <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        ctrl_en_r  <= bus.DAT_I[CTRL_EN];
        ctrl_ie_r  <= bus.DAT_I[CTRL_IE];
`ifdef UART_TX_PARITY_EN
        ctrl_pen_r <= bus.DAT_I[CTRL_PEN];
        ctrl_odd_r <= bus.DAT_I[CTRL_ODD];
`endif
      end
      if (wr_div_s) begin
        div_r <= bus.DAT_I[DIV_W-1:0];
      end
      if (done_set_s) begin
        done_r <= 1'b1;
      end else if ((wr_status_s && bus.DAT_I[STAT_DONE]) || wr_txdata_s) begin
        done_r <= 1'b0;
      end
      if (ovr_set_s) begin
        ovr_r <= 1'b1;
      end else if (wr_status_s && bus.DAT_I[STAT_OVR]) begin
        ovr_r <= 1'b0;
      end
    end
  end

  // Registered interrupt, one cycle behind DONE/BUSY/EMPTY.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= ctrl_ie_r & done_r & ~busy_s & fifo_empty_s;
    end
  end

  // Transmit FSM; txd_r is loaded with the level of the bit that starts next.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_r    <= ST_IDLE;
      txd_r      <= 1'b1;
      shift_r    <= 8'd0;
      bit_cnt_r  <= 3'd0;
      baud_cnt_r <= {DIV_W{1'b0}};
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shift_r    <= fifo_dout_s;
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= eff_div_m1_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= calc_parity(fifo_dout_s, ctrl_odd_r);
`endif
            state_r    <= ST_START;
            txd_r      <= 1'b0;
          end else begin
            txd_r <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r    <= ST_DATA;
            txd_r      <= shift_r[0];
            baud_cnt_r <= eff_div_m1_s;
          end else begin
            baud_cnt_r <= baud_cnt_r - DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            shift_r    <= shift_r >> 1;
            baud_cnt_r <= eff_div_m1_s;
            if (bit_cnt_r == 3'(FRAME_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              if (ctrl_pen_r) begin
                state_r <= ST_PARITY;
                txd_r   <= parity_r;
              end else begin
                state_r <= ST_STOP;
                txd_r   <= 1'b1;
              end
`else
              state_r <= ST_STOP;
              txd_r   <= 1'b1;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              txd_r     <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - DIV_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_s) begin
            state_r    <= ST_STOP;
            txd_r      <= 1'b1;
            baud_cnt_r <= eff_div_m1_s;
          end else begin
            baud_cnt_r <= baud_cnt_r - DIV_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_end_s) begin
            if (pop_s) begin
              shift_r    <= fifo_dout_s;
              bit_cnt_r  <= 3'd0;
              baud_cnt_r <= eff_div_m1_s;
`ifdef UART_TX_PARITY_EN
              parity_r   <= calc_parity(fifo_dout_s, ctrl_odd_r);
`endif
              state_r    <= ST_START;
              txd_r      <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              txd_r   <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - DIV_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          txd_r   <= 1'b1;
        end
      endcase
    end
  end

  assign IRQ = irq_r;
  assign TXD = txd_r;

endmodule
